// File: rtl/auth_pkg.sv
// auth_pkg: command bytes and transmit FSM states shared by the authentication link
package auth_pkg;
  localparam logic [7:0] CMD_GO = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/auth_cmd_tx_if.sv
// auth_cmd_tx_if: command request and UART status bundle of the authentication transmitter
interface auth_cmd_tx_if;
  logic send_go;
  logic send_stop;
  logic TX;
  logic busy;
  logic pending;
  logic done;
  modport master(output send_go, send_stop, input TX, busy, pending, done);
  modport slave(input send_go, send_stop, output TX, busy, pending, done);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART serialiser; trmt in the last stop clock chains the next frame with no gap
module uart_tx_core
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);
  tx_state_t state, nxt;
  logic [12:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic bit_end, load;
  assign bit_end = baud_cnt == 13'(BAUD_DIV - 1);
  assign load = trmt && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = trmt ? START : IDLE;
      START: nxt = bit_end ? DATA : START;
      DATA: nxt = bit_end && bit_cnt == 3'd7 ? STOP : DATA;
      STOP: nxt = bit_end ? (trmt ? START : IDLE) : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    TX = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    busy = state != IDLE;
    tx_done = state == STOP && bit_end;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
    end else begin
      baud_cnt <= (load || bit_end || state == IDLE) ? '0 : baud_cnt + 13'd1;
      if (load) begin
        shift <= tx_data;
        bit_cnt <= '0;
      end else if (state == DATA && bit_end) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
endmodule

// File: rtl/auth_cmd_tx.sv
// auth_cmd_tx: arbitrates G/S command requests into a one-deep buffer feeding the UART core
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input logic clk,
  input logic rst_n,
  auth_cmd_tx_if.slave cmd
);
  logic req, ready, trmt, pend_valid, core_busy, core_done;
  logic [7:0] req_byte, pend_byte, tx_data;
  assign req = cmd.send_go | cmd.send_stop;
  assign req_byte = cmd.send_stop ? CMD_STOP : CMD_GO;
  // core can take a byte when idle or in the final stop-bit clock
  assign ready = ~core_busy | core_done;
  assign trmt = ready & (pend_valid | req);
  assign tx_data = pend_valid ? pend_byte : req_byte;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_byte <= '0;
    end else if (req && !(ready && !pend_valid)) begin
      pend_valid <= 1'b1;
      pend_byte <= req_byte;
    end else if (ready && pend_valid) pend_valid <= 1'b0;
  uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .trmt(trmt),
    .tx_data(tx_data),
    .TX(cmd.TX),
    .tx_done(core_done),
    .busy(core_busy)
  );
  assign cmd.busy = core_busy;
  assign cmd.done = core_done;
  assign cmd.pending = pend_valid;
endmodule

// File: doc/auth_cmd_tx.md
Name: auth_cmd_tx

Overview:
- Transmit-side counterpart of the rider-authentication link: serialises the 'G' (power-up, 8'h47) and 'S' (app disconnected, 8'h53) command bytes onto a UART line in 8N1 format.
- Sits in the app/bridge side of the design and in system benches, driving the TX wire that the Segway authentication receiver samples.
- Accepts single-cycle command requests, buffers one pending command behind the frame in flight, and reports frame completion.

Parameters:
- BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600 baud); legal range 4..8191.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- send_go  input  1  single-cycle request to transmit 'G' (8'h47)
- send_stop  input  1  single-cycle request to transmit 'S' (8'h53)
- TX  output  1  UART serial out, idle high
- busy  output  1  high while a frame is on the line (start through stop bit)
- pending  output  1  high while a command is buffered behind the current frame
- done  output  1  single-cycle pulse on the last clock of each stop bit

Behaviour:
- Reset values: TX=1, busy=0, pending=0, done=0, FSM=IDLE, counters=0, pending buffer empty. Reset mid-frame aborts the frame immediately (TX=1 asynchronously); nothing resumes after reset.
- Request selection: send_stop and send_go in the same cycle selects 'S' (safety wins).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BAUD_DIV clocks, so a frame is 10*BAUD_DIV clocks.
- Latency: a request sampled in IDLE at edge n loads the shift register. TX goes 0 and busy goes 1 after edge n; busy stays high for 10*BAUD_DIV cycles.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: leave on an accepted request, or on a non-empty pending buffer.
  - START: leave after BAUD_DIV clocks.
  - DATA: shift right every BAUD_DIV clocks; a 3-bit bit counter leaves after bit 7.
  - STOP: leave after BAUD_DIV clocks and pulse done on the final clock.
- Baud counter: 13 bits, cleared on every bit boundary and on frame load. Bit counter wraps 7->0.
- Back-to-back frames:
  - If pending is set when STOP ends, the next frame's start bit begins on the very next clock (no idle gap).
  - busy stays high across the boundary.
  - done still pulses.
  - pending clears when the buffered byte loads.
- Pending buffer: one entry. A request arriving while busy is written into the buffer. A later request overwrites an earlier one (last command wins, 'S' beats 'G' within a cycle), so the buffer never overflows.
- A request arriving in the same cycle as the STOP-to-load transition goes into the buffer if a pending byte is loading; otherwise it loads directly.
- Requests are ignored only during reset; no request is lost except by overwrite.
- The byte in flight is captured at load and is unaffected by later requests.

Decomposition:
- Shared package auth_pkg:
  - constants CMD_GO=8'h47 and CMD_STOP=8'h53, shared with the receiving authentication block
  - typedef enum logic[1:0] tx_state_t {IDLE, START, DATA, STOP}
- One sub-module: uart_tx_core (baud counter, shift register, FSM; ports: trmt, tx_data[7:0], TX, tx_done, busy). It is reusable by other transmit paths.
- auth_cmd_tx wraps uart_tx_core with the request arbitration and the pending buffer.

Test Plan:
- BAUD_DIV=8 for all cases.
1. Idle after reset -> TX=1, busy=0, pending=0, done=0 for 100 cycles. Assert rst_n low mid-frame -> TX=1 and busy=0 at once; no frame after release.
2. send_go pulse -> TX low for 8 clocks, then data bits 1,1,1,0,0,0,1,0 for 8 clocks each, then high for 8 clocks. done pulses on cycle 80 after the request. busy is high for exactly 80 cycles.
3. send_stop pulse -> data bits 1,1,0,0,1,0,1,0 (8'h53). A loopback receiver reads 8'h53.
4. send_go and send_stop in the same cycle -> only 8'h53 is transmitted; pending=0 throughout.
5. send_go at t=0, then send_go at t=20 and send_stop at t=30 -> pending=1 from t=21 until the second frame loads. The second frame is 8'h53 with its start bit immediately after the first stop bit (no idle cycle). Two done pulses, 80 cycles apart.
6. Loop 50 random request sequences against a loopback receiver model -> every received byte equals the last-requested command per buffer rules, with no framing errors.
